// File: rtl/seq_mac_pkg.sv
// Shared definitions for the sequential multiply-accumulate block.
package seq_mac_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Ceiling log2, used to size the iteration counter.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/accum_sat.sv
// Accumulator with wrap or saturate behaviour and a sticky overflow flag.
module accum_sat
    import seq_mac_pkg::*;
#(
    parameter int PW   = 16,
    parameter int ABIT = 20,
    parameter int SAT  = 0
) (
    input  logic            C,
    input  logic            CLR,
    input  logic            ACC_CLR,
    input  logic            add_en,
    input  logic [PW-1:0]   addend,
    output logic [ABIT-1:0] ACC,
    output logic            OVF
);

    logic [ABIT:0] sum;

    // One extra bit so the carry out of the accumulator is visible.
    always_comb begin
        sum = {1'b0, ACC} + (ABIT+1)'(addend);
    end

    // Clear wins over add; a clear coinciding with an add loads the addend
    // directly, which cannot overflow because ABIT covers the product width.
    always_ff @(posedge C) begin
        if (CLR) begin
            ACC <= '0;
            OVF <= 1'b0;
        end else if (ACC_CLR) begin
            OVF <= 1'b0;
            ACC <= add_en ? ABIT'(addend) : '0;
        end else if (add_en) begin
            if (sum[ABIT]) begin
                OVF <= 1'b1;
                ACC <= (SAT != 0) ? '1 : sum[ABIT-1:0];
            end else begin
                ACC <= sum[ABIT-1:0];
            end
        end
    end

endmodule

// File: rtl/seq_mac.sv
// Iterative shift-and-add unsigned multiplier with optional accumulate.
// Fixed latency of Nbit cycles from the accepted START edge to DONE.
module seq_mac
    import seq_mac_pkg::*;
#(
    parameter int Nbit = 8,
    parameter int ABIT = 2*Nbit+4,
    parameter int SAT  = 0
) (
    input  logic              C,
    input  logic              CLR,
    input  logic              START,
    input  logic [Nbit-1:0]   A,
    input  logic [Nbit-1:0]   B,
    input  logic              ACC_EN,
    input  logic              ACC_CLR,
    output logic              BUSY,
    output logic              DONE,
    output logic [2*Nbit-1:0] P,
    output logic [ABIT-1:0]   ACC,
    output logic              OVF
);

    localparam int CW = clog2(Nbit) + 1;
    localparam int PW = 2*Nbit;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   mcand, psum, psum_nxt;
    logic [Nbit-1:0] mplr;
    logic            acc_en_r;
    logic            accept, last, add_en;

    // Next state plus the accept/last strobes that steer the datapath.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == CW'(Nbit-1)) begin
                    last      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Partial sum after this edge's step; also feeds the accumulator on the
    // final edge so ACC and P update together.
    always_comb begin
        psum_nxt = psum + (mplr[0] ? mcand : '0);
        add_en   = last & acc_en_r;
    end

    // State register.
    always_ff @(posedge C) begin
        if (CLR) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Shift-add datapath, handshake flags and product register.
    always_ff @(posedge C) begin
        if (CLR) begin
            cnt      <= '0;
            mcand    <= '0;
            mplr     <= '0;
            psum     <= '0;
            acc_en_r <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            P        <= '0;
        end else begin
            DONE <= 1'b0;
            if (accept) begin
                mcand    <= {{Nbit{1'b0}}, A};
                mplr     <= B;
                acc_en_r <= ACC_EN;
                psum     <= '0;
                cnt      <= '0;
                BUSY     <= 1'b1;
            end else if (state == ST_RUN) begin
                psum  <= psum_nxt;
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
                cnt   <= cnt + 1'b1;
                if (last) begin
                    P    <= psum_nxt;
                    DONE <= 1'b1;
                    BUSY <= 1'b0;
                end
            end
        end
    end

    accum_sat #(
        .PW  (PW),
        .ABIT(ABIT),
        .SAT (SAT)
    ) u_acc (
        .C      (C),
        .CLR    (CLR),
        .ACC_CLR(ACC_CLR),
        .add_en (add_en),
        .addend (psum_nxt),
        .ACC    (ACC),
        .OVF    (OVF)
    );

endmodule
